// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - request/grant and register-file write bundle for the write arbiter
//
// Groups two requester channels and the register-file write port.
//   a_valid/a_reg/a_data -> a_ready : writeback-stage request channel
//   b_valid/b_reg/b_data -> b_ready : multi-cycle unit request channel
//   reg_write/write_register/write_data : registered register-file write port
//   b_starved : high while the arbiter is forcing a grant to B
// Modports:
//   master : the requester/register-file side
//   slave  : the arbiter side
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              a_valid;
    logic [ADDR_W-1:0] a_reg;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;

    logic              b_valid;
    logic [ADDR_W-1:0] b_reg;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;

    logic              reg_write;
    logic [ADDR_W-1:0] write_register;
    logic [DATA_W-1:0] write_data;
    logic              b_starved;

    modport master (
        output a_valid, a_reg, a_data,
        input  a_ready,
        output b_valid, b_reg, b_data,
        input  b_ready,
        input  reg_write, write_register, write_data, b_starved
    );

    modport slave (
        input  a_valid, a_reg, a_data,
        output a_ready,
        input  b_valid, b_reg, b_data,
        output b_ready,
        output reg_write, write_register, write_data, b_starved
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester arbiter for the single register-file write port
//
// A (writeback stage) has fixed priority over B (multi-cycle unit). After MAX_WAIT
// consecutive denied cycles of B the arbiter enters B_PRIO and B wins the next cycle.
// A granted transfer in cycle N appears on the register-file write port in cycle N+1.
// Writes to register 0 are accepted but never asserted on reg_write.
// Ports:
//   i_clk : clock, all state on posedge
//   i_rst : synchronous reset, active-high
//   io_wr : slave side of regfile_write_arbiter_if (requests, readies, write port, b_starved)
module regfile_write_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    regfile_write_arbiter_if.slave  io_wr
);
    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    typedef enum logic {
        A_PRIO = 1'b0,
        B_PRIO = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_wait_cnt;
    logic [3:0]        w_wait_cnt_nxt;

    logic              w_a_ready;
    logic              w_b_ready;
    logic              w_a_xfer;
    logic              w_b_xfer;
    logic              w_xfer;
    logic              w_b_denied;
    logic [ADDR_W-1:0] w_sel_reg;
    logic [DATA_W-1:0] w_sel_data;

    logic              r_reg_write;
    logic [ADDR_W-1:0] r_write_register;
    logic [DATA_W-1:0] r_write_data;
    logic              r_b_starved;

    // Grant, wait counter and next-state logic. Readies are forced low during reset
    // so a request presented alongside reset is never considered accepted.
    always_comb begin
        w_a_ready      = 1'b0;
        w_b_ready      = 1'b0;
        w_b_denied     = 1'b0;
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;

        if (!i_rst) begin
            case (r_state)
                A_PRIO: begin
                    w_a_ready = io_wr.a_valid;
                    w_b_ready = io_wr.b_valid && !io_wr.a_valid;
                end
                B_PRIO: begin
                    w_b_ready = io_wr.b_valid;
                    w_a_ready = io_wr.a_valid && !io_wr.b_valid;
                end
                default: begin
                    w_a_ready = 1'b0;
                    w_b_ready = 1'b0;
                end
            endcase

            w_b_denied = io_wr.b_valid && !w_b_ready;

            if (w_b_denied) begin
                if (r_wait_cnt != LP_MAX_WAIT) begin
                    w_wait_cnt_nxt = r_wait_cnt + 4'd1;
                end
            end else begin
                w_wait_cnt_nxt = 4'd0;
            end

            case (r_state)
                A_PRIO: begin
                    // Switch on the very edge where the count reaches MAX_WAIT.
                    if (w_b_denied && (r_wait_cnt + 4'd1 == LP_MAX_WAIT)) begin
                        w_state_nxt = B_PRIO;
                    end
                end
                B_PRIO: begin
                    // A withdrawn B request also releases B_PRIO so A cannot lock up.
                    if (!io_wr.b_valid || w_b_ready) begin
                        w_state_nxt = A_PRIO;
                    end
                end
                default: w_state_nxt = A_PRIO;
            endcase
        end
    end

    assign w_a_xfer   = io_wr.a_valid && w_a_ready;
    assign w_b_xfer   = io_wr.b_valid && w_b_ready;
    assign w_xfer     = w_a_xfer || w_b_xfer;
    assign w_sel_reg  = w_b_xfer ? io_wr.b_reg  : io_wr.a_reg;
    assign w_sel_data = w_b_xfer ? io_wr.b_data : io_wr.a_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state          <= A_PRIO;
            r_wait_cnt       <= 4'd0;
            r_reg_write      <= 1'b0;
            r_write_register <= '0;
            r_write_data     <= '0;
            r_b_starved      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_b_starved <= (w_state_nxt == B_PRIO);
            // Register 0 is hardwired: accept the transfer but suppress the write strobe.
            r_reg_write <= w_xfer && (w_sel_reg != '0);
            if (w_xfer) begin
                r_write_register <= w_sel_reg;
                r_write_data     <= w_sel_data;
            end
        end
    end

    assign io_wr.a_ready        = w_a_ready;
    assign io_wr.b_ready        = w_b_ready;
    assign io_wr.reg_write      = r_reg_write;
    assign io_wr.write_register = r_write_register;
    assign io_wr.write_data     = r_write_data;
    assign io_wr.b_starved      = r_b_starved;
endmodule
